// File: rtl/classifier_pkg.sv
// Shared types and constants for the classifier frame driver slice.
// Holds the FSM state encoding and the config-channel register addresses.
package classifier_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] CFG_CUTOFF_FREQ   = 2'd0;
    localparam logic [1:0] CFG_CUTOFF_MAG    = 2'd1;
    localparam logic [1:0] CFG_SAMPLING_FREQ = 2'd2;

endpackage

// File: rtl/classifier_sample_deser.sv
// Word-serial to frame deserializer: writes each accepted word into the next
// buffer slot and flags the slot that completes a frame.
module classifier_sample_deser #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [BIT_WIDTH-1:0] d,
    output logic [BIT_WIDTH-1:0] q [N_SAMPLES],
    output logic                 last
);

    localparam int              CNT_W    = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign last = (cnt == CNT_LAST);

    // The counter wraps on the frame-completing word, so the next frame starts at slot 0.
    assign cnt_next = (clr || last) ? '0 : cnt + CNT_W'(1);

    cmn_EnResetReg #(.W(CNT_W)) cnt_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en || clr),
        .d     (cnt_next),
        .q     (cnt)
    );

    arr_EnResetReg #(.W(BIT_WIDTH), .N(N_SAMPLES)) buf_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .addr  (cnt),
        .d     (d),
        .q     (q)
    );

endmodule

// File: rtl/cmn_regs.sv
// Common enable/reset register primitives: a plain word register and an
// addressed register array, both with synchronous active-high reset.
module cmn_EnResetReg #(
    parameter int             W           = 1,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end

endmodule

module arr_EnResetReg #(
    parameter int W   = 32,
    parameter int N   = 8,
    parameter int A_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [A_W-1:0] addr,
    input  logic [W-1:0]   d,
    output logic [W-1:0]   q [N]
);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                q[i] <= '0;
        end else if (en) begin
            q[addr] <= d;
        end
    end

endmodule

// File: rtl/classifier_frame_driver.sv
// Producer-side partner of the classifier: collects a frame, offers it with the
// config words, takes the verdict back and forwards it tagged with a sequence number.
module classifier_frame_driver
    import classifier_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int SEQ_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 smp_val,
    output logic                 smp_rdy,
    input  logic [BIT_WIDTH-1:0] smp_msg,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [1:0]           cfg_addr,
    input  logic [BIT_WIDTH-1:0] cfg_data,
    output logic                 frm_val,
    input  logic                 frm_rdy,
    output logic [BIT_WIDTH-1:0] frm_msg [N_SAMPLES],
    output logic                 cf_val,
    input  logic                 cf_rdy,
    output logic [BIT_WIDTH-1:0] cf_msg,
    output logic                 cm_val,
    input  logic                 cm_rdy,
    output logic [BIT_WIDTH-1:0] cm_msg,
    output logic                 sf_val,
    input  logic                 sf_rdy,
    output logic [BIT_WIDTH-1:0] sf_msg,
    input  logic                 cls_val,
    output logic                 cls_rdy,
    input  logic                 cls_msg,
    output logic                 res_val,
    input  logic                 res_rdy,
    output logic [SEQ_W:0]       res_msg
);

    state_t           state;
    logic             smp_fire;
    logic             cfg_fire;
    logic             frm_fire;
    logic             cls_fire;
    logic             res_fire;
    logic             last;
    logic             verdict;
    logic [SEQ_W-1:0] seq;
    logic             unused_cfg_rdys;

    assign smp_fire = smp_val && smp_rdy;
    assign cfg_fire = cfg_val && cfg_rdy;
    assign frm_fire = frm_val && frm_rdy;
    assign cls_fire = cls_val && cls_rdy;
    assign res_fire = res_val && res_rdy;

    // The classifier raises all four readies together, so the frame handshake alone paces ISSUE.
    assign unused_cfg_rdys = ^{cf_rdy, cm_rdy, sf_rdy};

    classifier_sample_deser #(.BIT_WIDTH(BIT_WIDTH), .N_SAMPLES(N_SAMPLES)) deser (
        .clk   (clk),
        .reset (reset),
        .en    (smp_fire),
        .clr   (state != FILL),
        .d     (smp_msg),
        .q     (frm_msg),
        .last  (last)
    );

    cmn_EnResetReg #(.W(BIT_WIDTH)) cf_reg (
        .clk(clk), .reset(reset), .en(cfg_fire && cfg_addr == CFG_CUTOFF_FREQ),
        .d(cfg_data), .q(cf_msg)
    );

    cmn_EnResetReg #(.W(BIT_WIDTH)) cm_reg (
        .clk(clk), .reset(reset), .en(cfg_fire && cfg_addr == CFG_CUTOFF_MAG),
        .d(cfg_data), .q(cm_msg)
    );

    cmn_EnResetReg #(.W(BIT_WIDTH)) sf_reg (
        .clk(clk), .reset(reset), .en(cfg_fire && cfg_addr == CFG_SAMPLING_FREQ),
        .d(cfg_data), .q(sf_msg)
    );

    cmn_EnResetReg #(.W(1)) verdict_reg (
        .clk(clk), .reset(reset), .en(cls_fire), .d(cls_msg), .q(verdict)
    );

    cmn_EnResetReg #(.W(SEQ_W)) seq_reg (
        .clk(clk), .reset(reset), .en(res_fire), .d(seq + SEQ_W'(1)), .q(seq)
    );

    assign res_msg = {seq, verdict};

    // cfg_rdy drops for ISSUE only, so the config words cannot move while offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            smp_rdy <= 1'b1;
            cfg_rdy <= 1'b1;
            frm_val <= 1'b0;
            cf_val  <= 1'b0;
            cm_val  <= 1'b0;
            sf_val  <= 1'b0;
            cls_rdy <= 1'b0;
            res_val <= 1'b0;
        end else begin
            case (state)
                FILL: if (smp_fire && last) begin
                    state   <= ISSUE;
                    smp_rdy <= 1'b0;
                    cfg_rdy <= 1'b0;
                    frm_val <= 1'b1;
                    cf_val  <= 1'b1;
                    cm_val  <= 1'b1;
                    sf_val  <= 1'b1;
                end
                ISSUE: if (frm_fire) begin
                    state   <= WAIT;
                    frm_val <= 1'b0;
                    cf_val  <= 1'b0;
                    cm_val  <= 1'b0;
                    sf_val  <= 1'b0;
                    cfg_rdy <= 1'b1;
                    cls_rdy <= 1'b1;
                end
                WAIT: if (cls_fire) begin
                    state   <= OUT;
                    cls_rdy <= 1'b0;
                    res_val <= 1'b1;
                end
                OUT: if (res_fire) begin
                    state   <= FILL;
                    res_val <= 1'b0;
                    smp_rdy <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_classifier_frame_driver.sv
// Bench for classifier_frame_driver: directed and randomized frames checked against
// a queue/array model of the frame, config shadows and sequence tag.
module tb_classifier_frame_driver;

    localparam int BW = 32;
    localparam int NS = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          smp_val, smp_rdy;
    logic [BW-1:0] smp_msg;
    logic          cfg_val, cfg_rdy;
    logic [1:0]    cfg_addr;
    logic [BW-1:0] cfg_data;
    logic          frm_val, frm_rdy;
    logic [BW-1:0] frm_msg [NS];
    logic          cf_val, cf_rdy, cm_val, cm_rdy, sf_val, sf_rdy;
    logic [BW-1:0] cf_msg, cm_msg, sf_msg;
    logic          cls_val, cls_rdy, cls_msg;
    logic          res_val, res_rdy;
    logic [SW:0]   res_msg;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [BW-1:0] cfg_model [4];
    logic [BW-1:0] frame_q [$];
    int            seq_model;

    always #5 clk = ~clk;

    classifier_frame_driver #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .SEQ_W(SW)) dut (
        .clk(clk), .reset(reset),
        .smp_val(smp_val), .smp_rdy(smp_rdy), .smp_msg(smp_msg),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .frm_val(frm_val), .frm_rdy(frm_rdy), .frm_msg(frm_msg),
        .cf_val(cf_val), .cf_rdy(cf_rdy), .cf_msg(cf_msg),
        .cm_val(cm_val), .cm_rdy(cm_rdy), .cm_msg(cm_msg),
        .sf_val(sf_val), .sf_rdy(sf_rdy), .sf_msg(sf_msg),
        .cls_val(cls_val), .cls_rdy(cls_rdy), .cls_msg(cls_msg),
        .res_val(res_val), .res_rdy(res_rdy), .res_msg(res_msg)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset   = 1'b1;
        smp_val = 1'b0;
        cfg_val = 1'b0;
        frm_rdy = 1'b0; cf_rdy = 1'b0; cm_rdy = 1'b0; sf_rdy = 1'b0;
        cls_val = 1'b0;
        res_rdy = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) cfg_model[i] = '0;
        frame_q.delete();
        seq_model = 0;
        checkOutput("rst_smp_rdy", smp_rdy, 1);
        checkOutput("rst_cfg_rdy", cfg_rdy, 1);
        checkOutput("rst_frm_val", frm_val, 0);
        checkOutput("rst_cfg_vals", {cf_val, cm_val, sf_val}, 0);
        checkOutput("rst_cls_rdy", cls_rdy, 0);
        checkOutput("rst_res_val", res_val, 0);
        checkOutput("rst_res_msg", res_msg, 0);
        checkOutput("rst_cf_msg", cf_msg, 0);
        checkOutput("rst_cm_msg", cm_msg, 0);
        checkOutput("rst_sf_msg", sf_msg, 0);
        checkOutput("rst_frm_msg0", frm_msg[0], 0);
        checkOutput("rst_frm_msgN", frm_msg[NS-1], 0);
        reset = 1'b0;
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [BW-1:0] data);
        int waited = 0;
        while (!cfg_rdy && waited < 50) begin tick(); waited++; end
        if (!cfg_rdy) begin
            checkOutput("cfg_rdy_timeout", cfg_rdy, 1);
            return;
        end
        cfg_val = 1'b1; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_val = 1'b0; cfg_data = $urandom;
        if (addr != 2'd3) cfg_model[addr] = data;
    endtask

    // One sample word, optionally with a config write landing on the same edge.
    task automatic applyStimulus(input logic [BW-1:0] data, input bit with_cfg,
                                 input logic [1:0] addr, input logic [BW-1:0] cdata);
        int waited = 0;
        while (!(smp_rdy && (!with_cfg || cfg_rdy)) && waited < 50) begin tick(); waited++; end
        if (!smp_rdy) begin
            checkOutput("smp_rdy_timeout", smp_rdy, 1);
            return;
        end
        smp_val = 1'b1; smp_msg = data;
        if (with_cfg) begin cfg_val = 1'b1; cfg_addr = addr; cfg_data = cdata; end
        tick();
        smp_val = 1'b0; cfg_val = 1'b0; smp_msg = $urandom;
        frame_q.push_back(data);
        if (with_cfg && addr != 2'd3) cfg_model[addr] = cdata;
    endtask

    task automatic checkIssue(input string tag);
        checkOutput({tag, "_frm_val"}, frm_val, 1);
        checkOutput({tag, "_cfg_vals"}, {cf_val, cm_val, sf_val}, 3'b111);
        checkOutput({tag, "_smp_rdy"}, smp_rdy, 0);
        checkOutput({tag, "_cfg_rdy"}, cfg_rdy, 0);
        for (int i = 0; i < NS; i++)
            checkOutput($sformatf("%s_frm_msg%0d", tag, i), frm_msg[i],
                        (i < frame_q.size()) ? frame_q[i] : 'x);
        checkOutput({tag, "_cf_msg"}, cf_msg, cfg_model[0]);
        checkOutput({tag, "_cm_msg"}, cm_msg, cfg_model[1]);
        checkOutput({tag, "_sf_msg"}, sf_msg, cfg_model[2]);
    endtask

    // Drives the classifier and downstream sides for one issued frame.
    task automatic completeFrame(input int frm_hold, input int res_hold, input logic verdict);
        int          k;
        int          waited;
        logic [SW:0] exp_res;
        checkIssue("issue");
        for (int c = 0; c < frm_hold; c++) begin
            tick();
            k = $urandom_range(0, NS-1);
            checkOutput("hold_frm_val", frm_val, 1);
            checkOutput("hold_frm_msg", frm_msg[k], frame_q[k]);
            checkOutput("hold_cm_msg", cm_msg, cfg_model[1]);
            checkOutput("hold_sf_val", sf_val, 1);
            checkOutput("hold_rdys", {smp_rdy, cfg_rdy}, 2'b00);
        end
        frm_rdy = 1'b1; cf_rdy = 1'b1; cm_rdy = 1'b1; sf_rdy = 1'b1;
        tick();
        frm_rdy = 1'b0; cf_rdy = 1'b0; cm_rdy = 1'b0; sf_rdy = 1'b0;
        frame_q.delete();
        checkOutput("wait_vals", {frm_val, cf_val, cm_val, sf_val}, 0);
        checkOutput("wait_cls_rdy", cls_rdy, 1);
        checkOutput("wait_cfg_rdy", cfg_rdy, 1);
        repeat ($urandom_range(0, 2)) tick();
        cls_val = 1'b1; cls_msg = verdict;
        waited = 0;
        while (!cls_rdy && waited < 20) begin tick(); waited++; end
        if (!cls_rdy) begin
            checkOutput("cls_rdy_timeout", cls_rdy, 1);
            cls_val = 1'b0;
            return;
        end
        tick();
        cls_val = 1'b0; cls_msg = $urandom;
        exp_res = {SW'(seq_model), verdict};
        checkOutput("out_res_val", res_val, 1);
        checkOutput("out_res_msg", res_msg, exp_res);
        checkOutput("out_cls_rdy", cls_rdy, 0);
        for (int c = 0; c < res_hold; c++) begin
            tick();
            checkOutput("hold_res_msg", res_msg, exp_res);
            checkOutput("hold_smp_rdy", smp_rdy, 0);
        end
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        seq_model = (seq_model + 1) % (1 << SW);
        checkOutput("fill_res_val", res_val, 0);
        checkOutput("fill_smp_rdy", smp_rdy, 1);
    endtask

    initial begin
        logic [SW:0] last_res;
        smp_msg = '0; cfg_addr = '0; cfg_data = '0; cls_msg = 1'b0;
        $display("[TB] reset");
        doReset();

        $display("[TB] first frame, samples 1..8, verdict 1");
        cfgWrite(2'd0, 32'h0005_0000);
        cfgWrite(2'd1, 32'h0001_0000);
        cfgWrite(2'd2, 32'h0010_0000);
        for (int i = 1; i <= NS; i++) applyStimulus(BW'(i), 1'b0, 2'd0, '0);
        completeFrame(0, 0, 1'b1);

        $display("[TB] second frame, verdict 0");
        for (int i = 0; i < NS; i++) applyStimulus($urandom, 1'b0, 2'd0, '0);
        completeFrame(0, 0, 1'b0);

        $display("[TB] frame back-pressure for 10 cycles");
        for (int i = 0; i < NS; i++) applyStimulus($urandom, 1'b0, 2'd0, '0);
        completeFrame(10, 3, 1'($urandom));

        $display("[TB] cfg write with last sample, reserved address write");
        cfgWrite(2'd3, 32'hDEAD_BEEF);
        for (int i = 0; i < NS-1; i++) applyStimulus($urandom, 1'b0, 2'd0, '0);
        applyStimulus($urandom, 1'b1, 2'd1, 32'h0002_0000);
        checkOutput("same_cycle_cm_msg", cm_msg, 32'h0002_0000);
        completeFrame(0, 0, 1'b1);

        $display("[TB] reset after 5 samples");
        for (int i = 0; i < 5; i++) applyStimulus($urandom, 1'b0, 2'd0, '0);
        doReset();
        for (int i = 9; i <= 16; i++) applyStimulus(BW'(i), 1'b0, 2'd0, '0);
        checkOutput("post_rst_frm0", frm_msg[0], 9);
        completeFrame(0, 0, 1'b0);

        $display("[TB] 257 randomized frames");
        doReset();
        for (int f = 0; f < 257; f++) begin
            if ($urandom_range(0, 3) == 0)
                cfgWrite(2'($urandom_range(0, 3)), $urandom);
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 7) == 0)
                    applyStimulus($urandom, 1'b1, 2'($urandom_range(0, 3)), $urandom);
                else
                    applyStimulus($urandom, 1'b0, 2'd0, '0);
            end
            if (f == 256) begin
                // Force the last verdict to 1 so the wrapped tag is visible on the first OUT cycle.
                completeFrame($urandom_range(0, 2), 0, 1'b1);
            end else begin
                completeFrame($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
            end
        end
        last_res = {SW'(0), 1'b1};
        checkOutput("seq_model_wrapped", 64'(seq_model), 1);
        for (int i = 0; i < NS; i++) applyStimulus($urandom, 1'b0, 2'd0, '0);
        frm_rdy = 1'b1; cf_rdy = 1'b1; cm_rdy = 1'b1; sf_rdy = 1'b1;
        tick();
        frm_rdy = 1'b0; cf_rdy = 1'b0; cm_rdy = 1'b0; sf_rdy = 1'b0;
        frame_q.delete();
        cls_val = 1'b1; cls_msg = 1'b1;
        tick();
        cls_val = 1'b0;
        checkOutput("wrap_frame258_tag", res_msg, {SW'(1), 1'b1});
        checkOutput("wrap_frame258_val", res_val, 1);
        if (last_res[0] !== 1'b1) $display("[TB] note: unexpected local value");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
